out_reg_bank: RTL and testbench
===============================

# out_reg_bank

Parametrised multi-lane output register for the AP3 IO tile, next generation of the single-bit pad output flop. It registers a WIDTH-bit data word and a matching output-enable through a DEPTH-stage clock-enabled pipeline, with asynchronous reset and hold-to-preset, and reports when the pipeline contains real data. Each lane drives its own output pad; the block sits between fabric logic and the VPR output pads.

## Interface
- WIDTH, 1: number of data lanes, legal 1..32.
- DEPTH, 1: pipeline stages per lane, legal 1..4.
- RST_VAL, all zeros (WIDTH bits): value loaded into every data stage on rst.
- HOLD_VAL, all ones (WIDTH bits): value loaded into every data stage on hold.
- OE_RST, 0: value loaded into every OE stage on rst. Every OE stage loads 1 on hold.

- clk  in  1  clock; posedge only. Clock-buffer sink.
- rst  in  1  reset, asynchronous, active-high.
- hold  in  1  asynchronous active-high preset. Lower priority than rst.
- sel  in  1  pipeline advance enable. All stages shift together when high.
- dataIn  in  WIDTH  data word sampled into stage 0.
- oeIn  in  1  output-enable sampled into OE stage 0.
- dataOut  out  WIDTH  last data stage; one bit per pad.
- oeOut  out  1  last OE stage.
- valid  out  1  high when all DEPTH stages hold data loaded since the last rst or hold.

## Operation
- State: data stages s[0..DEPTH-1], each WIDTH bits; OE stages o[0..DEPTH-1]; fill counter cnt, width clog2(DEPTH+1), saturating at DEPTH.
- Priority, evaluated on posedge clk, posedge rst, or posedge hold:
  - rst=1: s[i]=RST_VAL, o[i]=OE_RST, cnt=0.
  - else hold=1: s[i]=HOLD_VAL, o[i]=1, cnt=0.
  - else sel=1 on posedge clk: s[0]=dataIn, o[0]=oeIn, s[i]=s[i-1] for i≥1, cnt=min(cnt+1, DEPTH).
  - else sel=0: all state holds.
- Outputs: dataOut=s[DEPTH-1], oeOut=o[DEPTH-1], valid=(cnt==DEPTH). All outputs are registered. There is no combinational path from any input to any output.
- Reset values: dataOut=RST_VAL, oeOut=OE_RST, valid=0.
- While rst or hold is held high, clk edges have no effect. Operation resumes on the first posedge clk after both are low.
- A hold pulse mid-stream discards the in-flight data, and valid drops to 0 asynchronously.
- DEPTH=1 behaves as the single-flop cell generalised to WIDTH lanes with OE, plus valid.
- Each lane ties dataOut[k] to its own output-pad instance, kept through synthesis and packed as the data-out-to-opad pattern.

## Timing
- Latency: dataIn and oeIn sampled on the n-th enabled edge appear at dataOut and oeOut after the (n+DEPTH-1)-th enabled edge, i.e. DEPTH sel-qualified edges.
- With sel held high, valid rises exactly DEPTH clk edges after rst or hold release.
- Disabled edges (sel=0) do not count toward latency or fill.
- Timing annotations:
  - dataIn, sel, oeIn: setup 0.1 ns to clk.
  - rst, hold: setup 0.1 ns to clk for release recovery.
  - dataOut, oeOut, valid: clk-to-q 0.1 ns.
  - Clock association is clk.
- rst and hold act within the same time step as their rising edge, with no clk edge required.

## Test plan
- Reset, WIDTH=8, DEPTH=3, RST_VAL=0x00, OE_RST=0: assert rst with no clk edge → dataOut=0x00, oeOut=0, valid=0 immediately.
- Streaming, WIDTH=8, DEPTH=3, sel=1: drive 0x11, 0x22, 0x33, 0x44 on successive edges → dataOut=0x11 after the 3rd edge and 0x44 after the 6th. valid rises after the 3rd edge. oeOut tracks oeIn with the same 3-edge lag.
- Stall, WIDTH=8, DEPTH=3: after loading 0x11 and 0x22, drop sel for 5 edges, then resume with 0x33 → state is frozen during the stall, dataOut=0x11 on the next enabled edge, and valid stays 0 until 3 enabled edges have occurred in total.
- Hold mid-stream, WIDTH=8, DEPTH=3, HOLD_VAL=0xFF, valid=1: pulse hold between edges → dataOut=0xFF, oeOut=1, valid=0 asynchronously. After release, valid returns after 3 enabled edges.
- Simultaneous events: rst and hold both high together with sel=1 and clk toggling → dataOut=RST_VAL and oeOut=OE_RST throughout. Release rst while hold stays high → dataOut=HOLD_VAL, oeOut=1.
- Edge configuration, WIDTH=1, DEPTH=1: sel=1, dataIn=1 → dataOut=1 and valid=1 after 1 edge. sel=0 with dataIn=0 → dataOut stays 1.

Source files
------------

// File: rtl/out_reg_bank.sv
// ---------------------------------------------------------------------------
// out_reg_bank
//
// Multi-lane registered pad output. A WIDTH-bit data word and a one-bit
// output-enable travel through a DEPTH-stage pipeline. Stages advance only on
// sel-qualified clock edges. There is an asynchronous reset and an
// asynchronous preset (hold), and valid reports that every stage has been
// refilled since the last rst or hold.
//
// Ports
//   clk      in   1      posedge clock
//   rst      in   1      async active-high reset (highest priority)
//   hold     in   1      async active-high preset (below rst)
//   sel      in   1      pipeline advance enable
//   dataIn   in   WIDTH  word sampled into stage 0
//   oeIn     in   1      output-enable sampled into OE stage 0
//   dataOut  out  WIDTH  last data stage, one bit per output pad
//   oeOut    out  1      last OE stage
//   valid    out  1      all DEPTH stages hold fresh data
//
// Handshake: no valid/ready flow control. sel is a plain enable. valid is a
// status flag only. It does not stall the pipeline and it is not
// back-pressured.
// ---------------------------------------------------------------------------
module out_reg_bank #(
  parameter int               WIDTH    = 1,
  parameter int               DEPTH    = 1,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter logic [WIDTH-1:0] HOLD_VAL = '1,
  parameter logic             OE_RST   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             sel,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             oeIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             oeOut,
  output logic             valid
);

  localparam int             CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] s;
  logic [DEPTH-1:0]            o;
  logic [CW-1:0]               cnt;
  logic [CW-1:0]               cnt_next;
  logic                        valid_q;

  // The fill count saturates at DEPTH. valid is kept in its own flop so that
  // the output is driven directly by a register and not by a compare.
  always_comb begin
    cnt_next = cnt;
    if (cnt != FULL) cnt_next = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst or posedge hold) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        s[i] <= RST_VAL;
        o[i] <= OE_RST;
      end
      cnt     <= '0;
      valid_q <= 1'b0;
    end else if (hold) begin
      for (int i = 0; i < DEPTH; i++) begin
        s[i] <= HOLD_VAL;
        o[i] <= 1'b1;
      end
      cnt     <= '0;
      valid_q <= 1'b0;
    end else if (sel) begin
      s[0] <= dataIn;
      o[0] <= oeIn;
      for (int i = 1; i < DEPTH; i++) begin
        s[i] <= s[i-1];
        o[i] <= o[i-1];
      end
      cnt     <= cnt_next;
      valid_q <= (cnt_next == FULL);
    end
  end

  // Each lane gets its own named net to its output pad. This keeps the
  // per-lane data-out-to-pad structure visible after elaboration.
  for (genvar k = 0; k < WIDTH; k++) begin : g_lane_pad
    assign dataOut[k] = s[DEPTH-1][k];
  end

  assign oeOut = o[DEPTH-1];
  assign valid = valid_q;

endmodule

// File: tb/tb_out_reg_bank.sv
// ---------------------------------------------------------------------------
// Bench for out_reg_bank. Instance A uses WIDTH=8 and DEPTH=3. Instance B uses
// WIDTH=1 and DEPTH=1. rst and hold are shared between the two instances.
// Stimulus pushes hand-computed expectations into exp_q and raises
// sample_ev. The monitor pops each expectation and compares it against the
// matching instance.
// ---------------------------------------------------------------------------
module tb_out_reg_bank;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic hold = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: WIDTH=8 DEPTH=3 ----------------
  logic       sel_a = 1'b0;
  logic [7:0] din_a = 8'h00;
  logic       oei_a = 1'b0;
  logic [7:0] dout_a;
  logic       oeo_a;
  logic       valid_a;

  out_reg_bank #(
    .WIDTH(8), .DEPTH(3), .RST_VAL(8'h00), .HOLD_VAL(8'hFF), .OE_RST(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .hold(hold), .sel(sel_a),
    .dataIn(din_a), .oeIn(oei_a),
    .dataOut(dout_a), .oeOut(oeo_a), .valid(valid_a)
  );

  // ---------------- DUT B: WIDTH=1 DEPTH=1 ----------------
  logic sel_b = 1'b0;
  logic din_b = 1'b0;
  logic oei_b = 1'b0;
  logic dout_b;
  logic oeo_b;
  logic valid_b;

  out_reg_bank #(
    .WIDTH(1), .DEPTH(1), .RST_VAL(1'b0), .HOLD_VAL(1'b1), .OE_RST(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .hold(hold), .sel(sel_b),
    .dataIn(din_b), .oeIn(oei_b),
    .dataOut(dout_b), .oeOut(oeo_b), .valid(valid_b)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {inst, data[7:0], oe, valid}. inst=1 selects DUT B.
  logic [10:0] exp_q[$];
  string       name_q[$];
  event        sample_ev;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic expect_a(input string nm, input logic [7:0] d,
                          input logic oe, input logic v);
    exp_q.push_back({1'b0, d, oe, v});
    name_q.push_back(nm);
    -> sample_ev;
    #1;
  endtask

  task automatic expect_b(input string nm, input logic d,
                          input logic oe, input logic v);
    exp_q.push_back({1'b1, 7'h00, d, oe, v});
    name_q.push_back(nm);
    -> sample_ev;
    #1;
  endtask

  // Monitor: compares the outputs the DUT presents against queued entries.
  initial begin
    logic [10:0] e;
    logic [10:0] act;
    string       nm;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e[10]) act = {1'b1, 7'h00, dout_b, oeo_b, valid_b};
        else       act = {1'b0, dout_a, oeo_a, valid_a};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: got data=%h oe=%b valid=%b, want data=%h oe=%b valid=%b",
                   nm, act[9:2], act[1], act[0], e[9:2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Moves to 1 time unit after the next rising clock edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic s, input logic [7:0] d, input logic oe);
    sel_a = s;
    din_a = d;
    oei_a = oe;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset is asserted with no clock edge and must act at once.
    #2 rst = 1'b1;
    #1;
    expect_a("rst_async_a", 8'h00, 1'b0, 1'b0);
    expect_b("rst_async_b", 1'b0, 1'b0, 1'b0);
    step();
    step();
    #2 rst = 1'b0;

    // Streaming test. oeIn sequence is 1,0,1,1,0,0.
    drive_a(1'b1, 8'h11, 1'b1); step();
    drive_a(1'b1, 8'h22, 1'b0); step();
    expect_a("stream_e2", 8'h00, 1'b0, 1'b0);
    drive_a(1'b1, 8'h33, 1'b1); step();
    expect_a("stream_e3", 8'h11, 1'b1, 1'b1);
    drive_a(1'b1, 8'h44, 1'b1); step();
    expect_a("stream_e4", 8'h22, 1'b0, 1'b1);
    drive_a(1'b1, 8'h55, 1'b0); step();
    expect_a("stream_e5", 8'h33, 1'b1, 1'b1);
    drive_a(1'b1, 8'h66, 1'b0); step();
    expect_a("stream_e6", 8'h44, 1'b1, 1'b1);

    // A hold pulse between edges clears the pipeline and drops valid.
    #2 hold = 1'b1;
    #1;
    expect_a("hold_async", 8'hFF, 1'b1, 1'b0);
    hold = 1'b0;
    drive_a(1'b1, 8'h77, 1'b0); step();
    expect_a("hold_refill1", 8'hFF, 1'b1, 1'b0);
    drive_a(1'b1, 8'h88, 1'b1); step();
    expect_a("hold_refill2", 8'hFF, 1'b1, 1'b0);
    drive_a(1'b1, 8'h99, 1'b0); step();
    expect_a("hold_refill3", 8'h77, 1'b0, 1'b1);

    // Stall test: load two words, hold sel low for 5 edges, then resume.
    drive_a(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    expect_a("stall_rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    drive_a(1'b1, 8'hAA, 1'b1); step();
    expect_a("stall_load1", 8'h00, 1'b0, 1'b0);
    drive_a(1'b1, 8'hBB, 1'b0); step();
    expect_a("stall_load2", 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, 8'hC0 + 8'(i), 1'b1);
      step();
    end
    expect_a("stall_frozen", 8'h00, 1'b0, 1'b0);
    drive_a(1'b1, 8'hCC, 1'b1); step();
    expect_a("stall_resume", 8'hAA, 1'b1, 1'b1);

    // rst and hold rise together while sel stays high: rst wins.
    drive_a(1'b1, 8'h12, 1'b1);
    #2;
    rst  = 1'b1;
    hold = 1'b1;
    #1;
    expect_a("both_async", 8'h00, 1'b0, 1'b0);
    step();
    expect_a("both_clk1", 8'h00, 1'b0, 1'b0);
    step();
    expect_a("both_clk2", 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b0;
    step();
    expect_a("hold_only", 8'hFF, 1'b1, 1'b0);
    #2 hold = 1'b0;
    drive_a(1'b1, 8'h5A, 1'b1); step();
    expect_a("after_release", 8'hFF, 1'b1, 1'b0);

    // Single-stage, single-lane instance.
    drive_a(1'b0, 8'h00, 1'b0);
    sel_b = 1'b1; din_b = 1'b1; oei_b = 1'b0;
    step();
    expect_b("b_load", 1'b1, 1'b0, 1'b1);
    sel_b = 1'b0; din_b = 1'b0; oei_b = 1'b1;
    step();
    expect_b("b_held", 1'b1, 1'b0, 1'b1);

    #5;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    n_bad++;
    $display("FAIL timeout: got no finish by 50000, want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
